mem_arbiter: RTL and testbench

- Shares one main-memory port between the instruction-fetch refill path (read-only) and the data-cache refill/writeback path.
- Arbitrates between the two requesters with round-robin priority.
- Sequences a fixed-length, line-aligned word burst for the granted requester and returns per-beat data/handshakes plus a completion pulse.
- Sits between the pipeline's I-side/D-side cache controllers and the backing memory model.

---
 rtl/mem_arb_pkg.sv | 33 +++
 rtl/mem_arb_rr_arb2.sv | 30 +++
 rtl/mem_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared types, constants and helpers for the memory-port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  localparam logic [1:0] C_ST_IDLE  = 2'b00;
  localparam logic [1:0] C_ST_BURST = 2'b01;
  localparam logic [1:0] C_ST_DONE  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = C_ST_IDLE,
    ST_BURST = C_ST_BURST,
    ST_DONE  = C_ST_DONE
  } arbState_t;

  typedef enum logic {
    GNT_INSTR = 1'b0,
    GNT_DATA  = 1'b1
  } grant_t;

  localparam int unsigned BURST_LEN_DEFAULT = 4;
  localparam int unsigned LINE_BYTES        = BURST_LEN_DEFAULT * 4;

  // Byte-offset mask of a line; callers truncate to their address width.
  function automatic logic [63:0] offsetMask(input int unsigned lineBytes);
    return 64'(lineBytes) - 64'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arb_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Purpose  : Two-input round-robin picker; on a tie the side that did not win
//            last time is chosen.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic   reqInstr,
  input  logic   reqData,
  input  grant_t lastGrant,
  output logic   gntValid,
  output grant_t gnt
);

  assign gntValid = reqInstr | reqData;

  always_comb begin
    gnt = GNT_INSTR;
    if (reqInstr && reqData) begin
      gnt = (lastGrant == GNT_DATA) ? GNT_INSTR : GNT_DATA;
    end else if (reqData) begin
      gnt = GNT_DATA;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one memory port between I-side refill and D-side
//            refill/writeback, sequencing line-aligned fixed-length bursts.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned BURST_LEN = BURST_LEN_DEFAULT,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_wready,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned          C_LINE_BYTES  = BURST_LEN * 4;
  localparam int unsigned          C_BEAT_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [C_BEAT_W-1:0]  C_LAST_BEAT   = C_BEAT_W'(BURST_LEN - 1);
  localparam logic [ADDR_W-1:0]    C_OFFSET_MASK = ADDR_W'(offsetMask(C_LINE_BYTES));

  arbState_t           r_state;
  grant_t              r_grant;
  grant_t              r_lastGrant;
  logic                r_we;
  logic [ADDR_W-1:0]   r_base;
  logic [C_BEAT_W-1:0] r_beat;

  logic   w_pickValid;
  grant_t w_pick;
  logic   w_inBurst;
  logic   w_inDone;
  logic   w_beatDone;

  rr_arb2 u_rrArb (
    .reqInstr  (i_req),
    .reqData   (d_req),
    .lastGrant (r_lastGrant),
    .gntValid  (w_pickValid),
    .gnt       (w_pick)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_grant     <= GNT_INSTR;
      r_lastGrant <= GNT_INSTR;
      r_we        <= 1'b0;
      r_base      <= '0;
      r_beat      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pickValid) begin
            r_grant <= w_pick;
            r_we    <= (w_pick == GNT_DATA) ? d_we : 1'b0;
            r_base  <= ((w_pick == GNT_DATA) ? d_addr : i_addr) & ~C_OFFSET_MASK;
            r_beat  <= '0;
            r_state <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (mem_ready) begin
            r_beat <= r_beat + C_BEAT_W'(1);
            if (r_beat == C_LAST_BEAT) begin
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          r_lastGrant <= r_grant;
          r_state     <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign w_inBurst  = (r_state == ST_BURST);
  assign w_inDone   = (r_state == ST_DONE);
  assign w_beatDone = w_inBurst && mem_ready;

  // Everything is gated by state so the idle side and idle port read as zero.
  assign mem_req   = w_inBurst;
  assign mem_we    = w_inBurst && r_we;
  assign mem_addr  = w_inBurst ? (r_base + (ADDR_W'(r_beat) << 2)) : '0;
  assign mem_wdata = (w_inBurst && r_we) ? d_wdata : '0;

  assign i_rvalid = w_beatDone && (r_grant == GNT_INSTR);
  assign i_rdata  = i_rvalid ? mem_rdata : '0;
  assign i_done   = w_inDone && (r_grant == GNT_INSTR);

  assign d_rvalid = w_beatDone && (r_grant == GNT_DATA) && !r_we;
  assign d_wready = w_beatDone && (r_grant == GNT_DATA) && r_we;
  assign d_rdata  = d_rvalid ? mem_rdata : '0;
  assign d_done   = w_inDone && (r_grant == GNT_DATA);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter: directed vector table,
//            reset-abort sequence and randomized round-robin traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int BL = 4;

  typedef struct {
    logic        reqI;
    logic        reqD;
    logic        dWe;
    logic [31:0] iAddr;
    logic [31:0] dAddr;
    int          stallBeat;
    int          stallCycles;
    logic        expData;
    logic [31:0] expBase;
  } vec_t;

  typedef struct {
    logic        iRvalid;
    logic [31:0] iRdata;
    logic        iDone;
    logic        dWready;
    logic        dRvalid;
    logic [31:0] dRdata;
    logic        dDone;
    logic        memReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
  } outs_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        iReq, dReq, dWe, memReady;
  logic [31:0] iAddr, dAddr, dWdata, memRdata;
  logic        iRvalid, iDone, dWready, dRvalid, dDone, memReq, memWe;
  logic [31:0] iRdata, dRdata, memAddr, memWdata;

  int checks = 0;
  int errors = 0;
  logic [31:0] simMem [logic [31:0]];
  logic [31:0] refMem [logic [31:0]];
  logic        lastData;
  vec_t        vecs [9];

  always #5 clk = ~clk;

  mem_arbiter #(.BURST_LEN(BL), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .i_req(iReq), .i_addr(iAddr), .i_rvalid(iRvalid), .i_rdata(iRdata), .i_done(iDone),
    .d_req(dReq), .d_we(dWe), .d_addr(dAddr), .d_wdata(dWdata), .d_wready(dWready),
    .d_rvalid(dRvalid), .d_rdata(dRdata), .d_done(dDone),
    .mem_req(memReq), .mem_we(memWe), .mem_addr(memAddr), .mem_wdata(memWdata),
    .mem_ready(memReady), .mem_rdata(memRdata)
  );

  function automatic logic [31:0] initWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] simRead(input logic [31:0] a);
    return simMem.exists(a) ? simMem[a] : initWord(a);
  endfunction

  function automatic logic [31:0] refRead(input logic [31:0] a);
    return refMem.exists(a) ? refMem[a] : initWord(a);
  endfunction

  function automatic vec_t mkVec(input logic rI, input logic rD, input logic we,
                                 input logic [31:0] aI, input logic [31:0] aD,
                                 input int sb, input int sc,
                                 input logic ed, input logic [31:0] eb);
    vec_t v;
    v.reqI = rI; v.reqD = rD; v.dWe = we; v.iAddr = aI; v.dAddr = aD;
    v.stallBeat = sb; v.stallCycles = sc; v.expData = ed; v.expBase = eb;
    return v;
  endfunction

  function automatic outs_t zeroOuts();
    outs_t e;
    e.iRvalid = 1'b0; e.iRdata = '0; e.iDone = 1'b0;
    e.dWready = 1'b0; e.dRvalid = 1'b0; e.dRdata = '0; e.dDone = 1'b0;
    e.memReq = 1'b0; e.memWe = 1'b0; e.memAddr = '0; e.memWdata = '0;
    return e;
  endfunction

  // What the spec says one BURST cycle must look like.
  function automatic outs_t beatOuts(input logic isData, input logic we,
                                     input logic [31:0] addr, input logic rdy,
                                     input logic [31:0] wdata);
    outs_t e = zeroOuts();
    e.memReq   = 1'b1;
    e.memWe    = we;
    e.memAddr  = addr;
    e.memWdata = we ? wdata : 32'h0;
    if (rdy) begin
      if (!isData) begin
        e.iRvalid = 1'b1; e.iRdata = refRead(addr);
      end else if (we) begin
        e.dWready = 1'b1;
      end else begin
        e.dRvalid = 1'b1; e.dRdata = refRead(addr);
      end
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic compare(input string tag, input outs_t e);
    chk({tag, ".i_rvalid"},  32'(iRvalid),  32'(e.iRvalid));
    chk({tag, ".i_rdata"},   iRdata,        e.iRdata);
    chk({tag, ".i_done"},    32'(iDone),    32'(e.iDone));
    chk({tag, ".d_wready"},  32'(dWready),  32'(e.dWready));
    chk({tag, ".d_rvalid"},  32'(dRvalid),  32'(e.dRvalid));
    chk({tag, ".d_rdata"},   dRdata,        e.dRdata);
    chk({tag, ".d_done"},    32'(dDone),    32'(e.dDone));
    chk({tag, ".mem_req"},   32'(memReq),   32'(e.memReq));
    chk({tag, ".mem_we"},    32'(memWe),    32'(e.memWe));
    chk({tag, ".mem_addr"},  memAddr,       e.memAddr);
    chk({tag, ".mem_wdata"}, memWdata,      e.memWdata);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory model: read data follows the presented address.
  task automatic setRdata();
    memRdata = simRead(memAddr);
  endtask

  task automatic idleCycle(input string tag);
    step();
    iReq = 1'b0; dReq = 1'b0; memReady = 1'($urandom_range(0, 1));
    setRdata();
    @(negedge clk);
    compare(tag, zeroOuts());
  endtask

  // One request/grant/burst/done transaction, checked cycle by cycle.
  task automatic runBurst(input vec_t v, input bit randReady, input string tag);
    logic        isData = v.expData;
    logic        we = v.expData && v.dWe;
    logic [31:0] wSeed = $urandom;
    logic [31:0] addr;
    logic        rdy;
    int beat = 0, stalls = 0, run = 0, strobes = 0;

    step();
    iReq = v.reqI; dReq = v.reqD; iAddr = v.iAddr; dAddr = v.dAddr; dWe = v.dWe;
    dWdata = wSeed; memReady = 1'($urandom_range(0, 1));
    setRdata();
    @(negedge clk);
    compare({tag, ".idle"}, zeroOuts());

    while (beat < BL) begin
      step();
      if (randReady) rdy = (run >= 3) || ($urandom_range(0, 2) != 0);
      else           rdy = !(beat == v.stallBeat && stalls < v.stallCycles);
      if (rdy) run = 0;
      else begin run++; stalls++; end
      memReady = rdy;
      dWdata   = wSeed + 32'(beat);
      setRdata();
      @(negedge clk);
      addr = v.expBase + 32'(4 * beat);
      compare({tag, ".beat"}, beatOuts(isData, we, addr, rdy, wSeed + 32'(beat)));
      if (memReq && memWe && memReady) simMem[memAddr] = memWdata;
      if (iRvalid || dRvalid || dWready) strobes++;
      if (rdy && we) refMem[addr] = wSeed + 32'(beat);
      if (rdy) beat++;
    end

    step();
    memReady = 1'($urandom_range(0, 1));
    setRdata();
    @(negedge clk);
    begin
      outs_t e = zeroOuts();
      if (isData) e.dDone = 1'b1;
      else        e.iDone = 1'b1;
      compare({tag, ".done"}, e);
    end
    chk({tag, ".strobes"}, 32'(strobes), 32'(BL));
    if (we) begin
      for (int k = 0; k < BL; k++) begin
        chk({tag, ".wrMem"}, simRead(v.expBase + 32'(4 * k)), refRead(v.expBase + 32'(4 * k)));
      end
    end
    lastData = isData;
    iReq = 1'b0;
    dReq = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = mkVec(1, 1, 0, 32'h7000, 32'h6000, -1, 0, 1, 32'h6000);
    vecs[1] = mkVec(1, 1, 0, 32'h7000, 32'h6004, -1, 0, 0, 32'h7000);
    vecs[2] = mkVec(1, 1, 1, 32'h7010, 32'h6010, -1, 0, 1, 32'h6010);
    vecs[3] = mkVec(1, 1, 0, 32'h701C, 32'h6000, -1, 0, 0, 32'h7010);
    vecs[4] = mkVec(1, 0, 0, 32'h1018, 32'h0,    -1, 0, 0, 32'h1010);
    vecs[5] = mkVec(0, 1, 1, 32'h0,    32'h2000, -1, 0, 1, 32'h2000);
    vecs[6] = mkVec(1, 0, 0, 32'h4008, 32'h0,     2, 3, 0, 32'h4000);
    vecs[7] = mkVec(0, 1, 0, 32'h0,    32'h5000, -1, 0, 1, 32'h5000);
    vecs[8] = mkVec(0, 1, 1, 32'h0,    32'h300F,  1, 2, 1, 32'h3000);

    rst = 1'b0; iReq = 1'b0; dReq = 1'b0; dWe = 1'b0;
    iAddr = '0; dAddr = '0; dWdata = '0; memReady = 1'b0; memRdata = '0;
    lastData = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    memReady = 1'b1;
    @(negedge clk);
    compare("reset", zeroOuts());
    step();
    rst = 1'b1;

    for (int i = 0; i < 9; i++) begin
      runBurst(vecs[i], 1'b0, $sformatf("vec%0d", i));
    end

    // Reset during beat 1 of a data read: abort, no done, tie then goes to DATA.
    step();
    iReq = 1'b0; dReq = 1'b1; dWe = 1'b0; dAddr = 32'h8000; memReady = 1'b1;
    setRdata();
    @(negedge clk);
    compare("rstIdle", zeroOuts());
    step();
    setRdata();
    @(negedge clk);
    compare("rstB0", beatOuts(1'b1, 1'b0, 32'h8000, 1'b1, 32'h0));
    step();
    rst = 1'b0;
    setRdata();
    @(negedge clk);
    compare("rstB1", beatOuts(1'b1, 1'b0, 32'h8004, 1'b1, 32'h0));
    step();
    rst = 1'b1; dReq = 1'b0;
    setRdata();
    @(negedge clk);
    compare("rstAfter", zeroOuts());
    idleCycle("rstAfter2");
    lastData = 1'b0;
    runBurst(mkVec(1, 1, 0, 32'h0100, 32'h0200, -1, 0, 1, 32'h0200), 1'b0, "rstTie");

    // Random traffic against the round-robin rule and a reference memory.
    for (int n = 0; n < 60; n++) begin
      vec_t v;
      int   k = $urandom_range(0, 2);
      v.reqI = (k != 1);
      v.reqD = (k != 0);
      v.dWe  = 1'($urandom_range(0, 1));
      v.iAddr = 32'($urandom_range(0, 255));
      v.dAddr = 32'($urandom_range(0, 255));
      v.stallBeat = -1;
      v.stallCycles = 0;
      v.expData = (v.reqI && v.reqD) ? !lastData : v.reqD;
      v.expBase = (v.expData ? v.dAddr : v.iAddr) & ~32'(BL * 4 - 1);
      runBurst(v, 1'b1, "rnd");
      if ($urandom_range(0, 3) == 0) idleCycle("rndIdle");
    end

    foreach (refMem[a]) begin
      chk("finalMem", simRead(a), refMem[a]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
